// File: rtl/shuffle_idx_gen_pkg.sv
// rtl/shuffle_idx_gen_pkg.sv - shared types and bit-reverse helper for the FFT reorder table
//
// Purpose : FSM state type for the reorder-table fill, and a bit-reverse
//           function sized for the widest supported index (also used by the
//           FFT reorder buffer).
// Contents: BITREV_MAX_W - widest index the helper handles
//           fill_state_e - FILL / DONE
//           bitrev()     - reverse the low 'width' bits of 'val', upper bits 0

package shuffle_idx_gen_pkg;

   localparam int BITREV_MAX_W = 10;

   typedef enum logic {
      FILL = 1'b0,
      DONE = 1'b1
   } fill_state_e;

   // out[k] = in[width-1-k] for k < width; bits at and above 'width' are 0.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(
      input logic [BITREV_MAX_W-1:0] val,
      input int unsigned             width
   );
      logic [BITREV_MAX_W-1:0] res;
      res = '0;
      for (int k = 0; k < BITREV_MAX_W; k++) begin
         if (k < int'(width)) begin
            res[k] = val[int'(width) - 1 - k];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/shuffle_idx_gen_bitrev.sv
// rtl/shuffle_idx_gen_bitrev.sv - combinational W-bit bit-reversal leaf
//
// Purpose : dout[k] = din[W-1-k]. Pure wiring, shared by the table write
//           path and the lookup path so both use the same mapping.
// Ports   : din  in  W  index to reverse
//           dout out W  bit-reversed index

module shuffle_idx_gen_bitrev #(
   parameter int W = 4
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   for (genvar k = 0; k < W; k++) begin : g_rev
      assign dout[k] = din[W-1-k];
   end

endmodule

// File: rtl/shuffle_idx_gen.sv
// rtl/shuffle_idx_gen.sv - radix-2 SDF FFT bit-reversed reorder table generator
//
// Purpose : After reset (or a regen pulse) fills a 2^N-entry table, one entry
//           per clock, with entry[i] = bitrev(i); then holds it. A separate
//           registered lookup port returns bitrev(lk_addr) one cycle later,
//           computed directly so it is usable before the table is complete.
// Params  : N  index width, legal range 1..10; table depth is 2^N.
// Ports   : clk          in   1        rising-edge clock
//           rst_n        in   1        asynchronous active-low reset
//           regen        in   1        one-cycle pulse: clear table, restart fill
//           shuffle_idx  out  N*2^N    flat table, entry i at [i*N +: N]
//           done         out  1        every entry written
//           lk_addr      in   N        lookup address
//           lk_data      out  N        registered bitrev(lk_addr)

module shuffle_idx_gen
   import shuffle_idx_gen_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  regen,
   output logic [N*(2**N)-1:0]   shuffle_idx,
   output logic                  done,
   input  logic [N-1:0]          lk_addr,
   output logic [N-1:0]          lk_data
);

   localparam int             DEPTH    = 2**N;
   localparam logic [N-1:0]   LAST_IDX = N'(DEPTH - 1);

   fill_state_e   state_q, state_d;
   logic [N-1:0]  cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [N-1:0]  table_q [DEPTH];
   logic [N-1:0]  table_d [DEPTH];
   logic [N-1:0]  lk_data_q, lk_data_d;

   logic [N-1:0]  wr_rev;
   logic [N-1:0]  lk_rev;

   shuffle_idx_gen_bitrev #(.W(N)) u_wr_rev (
      .din  (cnt_q),
      .dout (wr_rev)
   );

   shuffle_idx_gen_bitrev #(.W(N)) u_lk_rev (
      .din  (lk_addr),
      .dout (lk_rev)
   );

   // Next-state: regen overrides everything, including the write for this edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      table_d   = table_q;
      lk_data_d = lk_rev;

      if (regen) begin
         state_d = FILL;
         cnt_d   = '0;
         done_d  = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = '0;
         end
      end else begin
         case (state_q)
            FILL: begin
               table_d[cnt_q] = wr_rev;
               if (cnt_q == LAST_IDX) begin
                  // Counter is left at the last index rather than wrapping to 0.
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + N'(1);
               end
            end
            DONE: begin
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         lk_data_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         lk_data_q <= lk_data_d;
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

   always_comb begin
      shuffle_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         shuffle_idx[i*N +: N] = table_q[i];
      end
   end

   assign done    = done_q;
   assign lk_data = lk_data_q;

endmodule

// File: tb/tb_shuffle_idx_gen.sv
// tb/tb_shuffle_idx_gen.sv - directed self-checking bench for shuffle_idx_gen (N=4 and N=3)

module tb_shuffle_idx_gen;

   localparam logic [63:0] FULL4 = 64'hF7B3D591E6A2C480;
   localparam logic [63:0] PART4 = 64'h0000000000000480;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        regen = 1'b0;

   logic [63:0] shuffle4;
   logic        done4;
   logic [3:0]  lk_addr4 = '0;
   logic [3:0]  lk_data4;

   logic [23:0] shuffle3;
   logic        done3;
   logic [2:0]  lk_addr3 = '0;
   logic [2:0]  lk_data3;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [3:0] exp4 [16];
   logic [2:0] exp3 [8];

   always #5 clk = ~clk;

   shuffle_idx_gen #(.N(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .regen       (regen),
      .shuffle_idx (shuffle4),
      .done        (done4),
      .lk_addr     (lk_addr4),
      .lk_data     (lk_data4)
   );

   shuffle_idx_gen #(.N(3)) dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .regen       (regen),
      .shuffle_idx (shuffle3),
      .done        (done3),
      .lk_addr     (lk_addr3),
      .lk_data     (lk_data3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges, release between edges so the next posedge is edge 1.
   task automatic do_reset();
      rst_n = 1'b0;
      regen = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (shuffle4 !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_table4: got %h expected 0", shuffle4);
      end
      tests_run++;
      if (done4 !== 1'b0 || done3 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b/%b expected 0/0", done4, done3);
      end
      tests_run++;
      if (lk_data4 !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_lk_data: got %h expected 0", lk_data4);
      end
   endtask

   task automatic test_fill_latency();
      do_reset();
      for (int e = 1; e <= 16; e++) begin
         tick();
         tests_run++;
         if (done4 !== (e == 16)) begin
            tests_failed++;
            $display("FAIL fill_done_edge%0d: got %b expected %b", e, done4, (e == 16));
         end
      end
      tests_run++;
      if (shuffle4 !== FULL4) begin
         tests_failed++;
         $display("FAIL full_table4: got %h expected %h", shuffle4, FULL4);
      end
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (shuffle4[i*4 +: 4] !== exp4[i]) begin
            tests_failed++;
            $display("FAIL entry4_%0d: got %0d expected %0d", i, shuffle4[i*4 +: 4], exp4[i]);
         end
      end
      // Table must hold once done.
      repeat (5) tick();
      tests_run++;
      if (shuffle4 !== FULL4 || done4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_after_done: got %h/%b expected %h/1", shuffle4, done4, FULL4);
      end
   endtask

   task automatic test_partial_fill();
      do_reset();
      repeat (3) tick();
      tests_run++;
      if (shuffle4 !== PART4) begin
         tests_failed++;
         $display("FAIL partial_table: got %h expected %h", shuffle4, PART4);
      end
      tests_run++;
      if (done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL partial_done: got %b expected 0", done4);
      end
   endtask

   task automatic test_lookup();
      do_reset();
      lk_addr4 = 4'd1;
      tick();
      tests_run++;
      if (lk_data4 !== 4'd8 || done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL lookup_before_done: got %0d/%b expected 8/0", lk_data4, done4);
      end
      lk_addr4 = 4'b0011;
      tick();
      tests_run++;
      if (lk_data4 !== 4'b1100) begin
         tests_failed++;
         $display("FAIL lookup_0011: got %b expected 1100", lk_data4);
      end
      // Back-to-back addresses: each result appears one edge after its address.
      for (int i = 0; i < 16; i++) begin
         lk_addr4 = 4'(i);
         tick();
         tests_run++;
         if (lk_data4 !== exp4[i]) begin
            tests_failed++;
            $display("FAIL lookup4_%0d: got %0d expected %0d", i, lk_data4, exp4[i]);
         end
      end
      // Involution through the lookup port.
      for (int i = 0; i < 16; i++) begin
         lk_addr4 = exp4[i];
         tick();
         tests_run++;
         if (lk_data4 !== 4'(i)) begin
            tests_failed++;
            $display("FAIL involution4_%0d: got %0d expected %0d", i, lk_data4, i);
         end
      end
   endtask

   task automatic test_regen_after_done();
      do_reset();
      repeat (16) tick();
      regen = 1'b1;
      tick();
      regen = 1'b0;
      tests_run++;
      if (shuffle4 !== 64'h0 || done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL regen_clear: got %h/%b expected 0/0", shuffle4, done4);
      end
      repeat (15) tick();
      tests_run++;
      if (done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL regen_done_early: got %b expected 0", done4);
      end
      tick();
      tests_run++;
      if (done4 !== 1'b1 || shuffle4 !== FULL4) begin
         tests_failed++;
         $display("FAIL regen_refill: got %h/%b expected %h/1", shuffle4, done4, FULL4);
      end
   endtask

   task automatic test_regen_mid_fill();
      do_reset();
      repeat (5) tick();
      regen = 1'b1;
      tick();
      regen = 1'b0;
      tests_run++;
      if (shuffle4 !== 64'h0) begin
         tests_failed++;
         $display("FAIL regen_mid_priority: got %h expected 0", shuffle4);
      end
      repeat (3) tick();
      tests_run++;
      if (shuffle4 !== PART4 || done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL regen_mid_restart: got %h/%b expected %h/0", shuffle4, done4, PART4);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      lk_addr4 = 4'd3;
      repeat (7) tick();
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (shuffle4 !== 64'h0 || done4 !== 1'b0 || lk_data4 !== 4'h0) begin
         tests_failed++;
         $display("FAIL async_reset: got %h/%b/%h expected 0/0/0", shuffle4, done4, lk_data4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) tick();
      tests_run++;
      if (done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_restart_early: got %b expected 0", done4);
      end
      tick();
      tests_run++;
      if (done4 !== 1'b1 || shuffle4 !== FULL4) begin
         tests_failed++;
         $display("FAIL async_restart_full: got %h/%b expected %h/1", shuffle4, done4, FULL4);
      end
   endtask

   task automatic test_n3();
      do_reset();
      repeat (7) tick();
      tests_run++;
      if (done3 !== 1'b0) begin
         tests_failed++;
         $display("FAIL n3_done_early: got %b expected 0", done3);
      end
      tick();
      tests_run++;
      if (done3 !== 1'b1) begin
         tests_failed++;
         $display("FAIL n3_done: got %b expected 1", done3);
      end
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (shuffle3[i*3 +: 3] !== exp3[i]) begin
            tests_failed++;
            $display("FAIL entry3_%0d: got %0d expected %0d", i, shuffle3[i*3 +: 3], exp3[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         lk_addr3 = exp3[i];
         tick();
         tests_run++;
         if (lk_data3 !== 3'(i)) begin
            tests_failed++;
            $display("FAIL involution3_%0d: got %0d expected %0d", i, lk_data3, i);
         end
      end
   endtask

   initial begin
      exp4 = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
               4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
      exp3 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

      test_reset();
      test_fill_latency();
      test_partial_fill();
      test_lookup();
      test_regen_after_done();
      test_regen_mid_fill();
      test_async_reset();
      test_n3();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/shuffle_idx_gen.md
Name: shuffle_idx_gen

Overview:
- Produces the radix-2 SDF FFT reorder table: entry i = bit-reversal of the N-bit index i, for all 2^N indices.
- The table is built sequentially after reset, one entry per clock, then held static.
- Output ordering stages read it as a flat bus, or through a one-cycle registered lookup port.

Parameters:
- N, default 4, index width in bits; table depth is 2^N. Legal range 1..10.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- regen  in  1  single-cycle pulse; clears the table and restarts the fill.
- shuffle_idx  out  N*2^N  flat table; entry i occupies bits [i*N +: N].
- done  out  1  high when every entry is valid.
- lk_addr  in  N  lookup address.
- lk_data  out  N  registered bit-reversed value of lk_addr.

Behaviour:
- Reset (rst_n=0, asynchronous): all table entries=0, fill counter=0, done=0, lk_data=0, FSM=FILL.
- FSM states:
  - FILL: each rising edge writes entry[cnt] = bitrev(cnt), then cnt increments. When cnt = 2^N-1 is written, go to DONE on that same edge and set done=1.
  - DONE: the table holds. done stays 1.
- Fill latency: done rises on the 2^N-th rising edge after rst_n deasserts. The fill takes exactly 2^N cycles and is unaffected by other inputs.
- bitrev definition: out[k] = in[N-1-k] for k=0..N-1. The mapping is an involution. For N=1 the table is identity.
- regen=1 in any state: on the next edge, all entries=0, cnt=0, done=0, FSM=FILL.
- regen during FILL restarts the fill from index 0. regen has priority over the fill write.
- lk_data: registered every cycle, lk_data <= bitrev(lk_addr).
  - It is computed directly, not read from the table, so it is valid regardless of done.
  - Latency is 1 cycle.
- Counter width is N bits. Its wrap from 2^N-1 back to 0 is suppressed by the transition to DONE.
- rst_n assertion mid-fill clears everything immediately, regardless of clock.
- Entries not yet written read 0.

Decomposition:
- Shared package holds a bitrev function (parameterised by width) and the FSM state enum {FILL, DONE}.
- The function is reused by the FFT reorder buffer.
- No sub-module is needed. An optional leaf bit_reverse (combinational, width N) can be shared by the table write path and the lookup path.

Test Plan:
- N=4, release reset, count 16 edges: done rises on edge 16. Then entry1=8, entry2=4, entry3=12, entry5=10, entry6=6, entry15=15, entry0=0.
- N=4, sample after 3 edges: entries 0..2 = {0,8,4}, entries 3..15 = 0, done=0.
- N=4, lk_addr=4'b0011 at edge k: lk_data=4'b1100 at edge k. lk_addr=1 gives 8 before done is set.
- Pulse regen after done: next edge all entries=0 and done=0. done rises again 16 edges later with an identical table.
- Assert rst_n low asynchronously mid-fill (between edges): outputs zero immediately. Fill restarts on release.
- N=3 (depth 8): table = {0,4,2,6,1,5,3,7}, done after 8 edges. Check the involution bitrev(bitrev(i))=i for all i.
